gray_monitor: RTL and testbench
===============================

# gray_monitor

Downstream consumer for the Gray-code counter stage. Samples a WIDTH-bit Gray code on a valid strobe and converts it to binary. Checks that every accepted step is a single-position move, tracks step direction and counts wrap-arounds. Latches a sticky error on any illegal jump; the error stays set until explicitly cleared.

## Interface
Parameters:
- WIDTH, 3, Gray/binary code width; legal range 2..16.
- CNT_W, 8, width of the wrap counter.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high; highest priority.
- Clear  in  1  synchronous clear of error/lock/wrap state; priority below Reset, above Valid.
- Valid  in  1  sample strobe; Gray is ignored when low.
- Gray  in  WIDTH  Gray-coded input value.
- Bin  out  WIDTH  binary value of the last accepted sample.
- Locked  out  1  high while in TRACK.
- Err  out  1  high while in ERR.
- Dir  out  1  direction of the last accepted step (1 = up, 0 = down).
- Step  out  1  one-cycle pulse when a ±1 step is accepted.
- Wraps  out  CNT_W  net wrap-around count, saturating.

## Operation
- Conversion is combinational: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i]. Call the result newb.
- delta = newb − Bin, computed modulo 2^WIDTH.
- FSM states are IDLE, TRACK and ERR. Reset enters IDLE.
- IDLE, Valid=1: Bin<=newb, go to TRACK. Step stays 0, Dir and Wraps unchanged.
- TRACK, Valid=1, delta==0: repeat sample, no change, Step=0.
- TRACK, Valid=1, delta==1: Bin<=newb, Dir<=1, Step pulses. If Bin==2^W−1 and newb==0, Wraps increments, saturating at 2^CNT_W−1.
- TRACK, Valid=1, delta==2^W−1 (down step): handling depends on the macro; see Configuration.
- TRACK, Valid=1, any other delta: go to ERR. Bin, Dir and Wraps are held at their last good values. Step=0.
- ERR: Valid is ignored. Leave only via Clear (to IDLE) or Reset.
- Clear=1 in any state: go to IDLE, Wraps<=0. Bin and Dir are retained. Valid in the same cycle is ignored.
- Valid=0: state and outputs hold, except Step, which is 0.

## Timing
- All outputs are registered. A sample presented with Valid at edge N is reflected on the outputs after edge N.
- Step is high for exactly the one cycle following the accepting edge.
- Locked=1 and Err=0 in TRACK. Locked=0 and Err=1 in ERR. Locked=0 and Err=0 in IDLE.
- Reset values: Bin=0, Locked=0, Err=0, Dir=1, Step=0, Wraps=0, state=IDLE.
- Reset mid-operation discards all tracking state on that same edge.
- Priority on the same edge: Reset > Clear > Valid.
- Back-to-back Valid on every cycle is supported. There is no throughput limit.

## Configuration
- GRAY_MON_BIDIR_EN defined: a down step (delta==2^W−1) is legal.
  - Bin<=newb, Dir<=0, Step pulses.
  - If Bin==0 and newb==2^W−1, Wraps decrements, saturating at 0.
- GRAY_MON_BIDIR_EN undefined: a down step is an illegal jump.
  - Go to ERR, exactly as for any other illegal delta.
  - Dir is then constant 1.

## Test plan
- WIDTH=3. Reset, then Valid on Gray 000,001,011,010,110,111,101,100,000 -> Bin 0..7 then 0; Step pulses 8 times; Wraps=1; Locked=1; Err=0.
- In TRACK with Bin=1, present Gray 010 (binary 3) -> Err=1 and Locked=0 next cycle; Bin stays 1. Further Valid samples are ignored until Clear.
- From Bin=2 (Gray 011), present Gray 001:
  - Macro on -> Bin=1, Dir=0, Step pulses.
  - Macro off -> Err=1, Bin=2.
- Repeat the same Gray value 5 times in TRACK -> no Step pulses, all outputs unchanged.
- CNT_W=2, run 5 full up-cycles -> Wraps saturates at 3. Then Clear with Valid=1 -> IDLE, Wraps=0, the sample is ignored, and the next Valid relocks.
- Assert Reset mid-sequence with Valid=1 -> all outputs at reset values next cycle, state IDLE.

Source files
------------

// File: rtl/gray_monitor.sv
// rtl/gray_monitor.sv - Gray-code step monitor with binary conversion, direction and wrap tracking
//
// Samples a WIDTH-bit Gray code on Valid and converts it to binary. The
// monitor accepts only single-position moves. Any other jump latches a
// sticky error until Clear or Reset. Wrap-arounds are counted into a
// saturating net counter.
//
// Optional feature macro: GRAY_MON_BIDIR_EN
//   defined   - a -1 step is legal; it sets Dir=0 and can decrement Wraps
//   undefined - a -1 step is an illegal jump; Dir is constant 1
//
// Ports:
//   Clk     in   clock, rising edge
//   Reset   in   synchronous, active-high, highest priority
//   Clear   in   synchronous clear of error/lock/wrap state (below Reset)
//   Valid   in   sample strobe
//   Gray    in   [WIDTH]  Gray-coded sample
//   Bin     out  [WIDTH]  binary value of last accepted sample
//   Locked  out  high in TRACK
//   Err     out  high in ERR
//   Dir     out  direction of last accepted step (1 = up)
//   Step    out  one-cycle pulse per accepted step
//   Wraps   out  [CNT_W]  net wrap count, saturating
module gray_monitor #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Clear,
    input  logic             Valid,
    input  logic [WIDTH-1:0] Gray,
    output logic [WIDTH-1:0] Bin,
    output logic             Locked,
    output logic             Err,
    output logic             Dir,
    output logic             Step,
    output logic [CNT_W-1:0] Wraps
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRACK,
        S_ERR
    } state_t;

    localparam logic [WIDTH-1:0] BIN_ZERO = '0;
    localparam logic [WIDTH-1:0] BIN_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] BIN_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state;
    logic [WIDTH-1:0] newb;
    logic [WIDTH-1:0] delta;

    // Binary bit i is the XOR of Gray bits i..WIDTH-1; written as a
    // reduction over a shifted copy so there is no bit-to-bit comb chain.
    always_comb begin
        newb = '0;
        for (int i = 0; i < WIDTH; i++) begin
            newb[i] = ^(Gray >> i);
        end
    end

    // Modulo-2^WIDTH difference: +1 is an up step, all-ones is a down step.
    assign delta = newb - Bin;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= S_IDLE;
            Bin    <= '0;
            Locked <= 1'b0;
            Err    <= 1'b0;
            Dir    <= 1'b1;
            Step   <= 1'b0;
            Wraps  <= '0;
        end else begin
            Step <= 1'b0;
            if (Clear) begin
                // Bin and Dir deliberately survive a Clear.
                state  <= S_IDLE;
                Locked <= 1'b0;
                Err    <= 1'b0;
                Wraps  <= '0;
            end else if (Valid) begin
                case (state)
                    S_IDLE: begin
                        Bin    <= newb;
                        state  <= S_TRACK;
                        Locked <= 1'b1;
                        Err    <= 1'b0;
                    end
                    S_TRACK: begin
                        if (delta == BIN_ZERO) begin
                            // Repeat sample: nothing moves.
                        end else if (delta == BIN_ONE) begin
                            Bin  <= newb;
                            Dir  <= 1'b1;
                            Step <= 1'b1;
                            if (Bin == BIN_MAX && Wraps != CNT_MAX) begin
                                Wraps <= Wraps + CNT_ONE;
                            end
                        end
`ifdef GRAY_MON_BIDIR_EN
                        else if (delta == BIN_MAX) begin
                            Bin  <= newb;
                            Dir  <= 1'b0;
                            Step <= 1'b1;
                            if (Bin == BIN_ZERO && Wraps != CNT_ZERO) begin
                                Wraps <= Wraps - CNT_ONE;
                            end
                        end
`endif
                        else begin
                            // Illegal jump: hold last good Bin/Dir/Wraps.
                            state  <= S_ERR;
                            Locked <= 1'b0;
                            Err    <= 1'b1;
                        end
                    end
                    default: begin
                        // ERR: samples ignored until Clear or Reset.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gray_monitor.sv
// tb/tb_gray_monitor.sv - scoreboard bench for gray_monitor (WIDTH=3, CNT_W=2)
module tb_gray_monitor;

    localparam int WIDTH = 3;
    localparam int CNT_W = 2;
    localparam int MASK  = (1 << WIDTH) - 1;
    localparam int WMAX  = (1 << CNT_W) - 1;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic             Clear = 1'b0;
    logic             Valid = 1'b0;
    logic [WIDTH-1:0] Gray = '0;
    logic [WIDTH-1:0] Bin;
    logic             Locked;
    logic             Err;
    logic             Dir;
    logic             Step;
    logic [CNT_W-1:0] Wraps;

    gray_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Clear  (Clear),
        .Valid  (Valid),
        .Gray   (Gray),
        .Bin    (Bin),
        .Locked (Locked),
        .Err    (Err),
        .Dir    (Dir),
        .Step   (Step),
        .Wraps  (Wraps)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int bin;
        int locked;
        int err;
        int dir;
        int step;
        int wraps;
    } exp_t;

    exp_t sb[$];

    // Reference model state: 0 = IDLE, 1 = TRACK, 2 = ERR
    int m_state = 0;
    int m_bin   = 0;
    int m_dir   = 1;
    int m_step  = 0;
    int m_wraps = 0;

    int n_checks  = 0;
    int n_pass    = 0;
    int step_seen = 0;

`ifdef GRAY_MON_BIDIR_EN
    localparam int BIDIR = 1;
`else
    localparam int BIDIR = 0;
`endif

    function automatic int g2b(input int g);
        int b = 0;
        for (int s = 0; s < WIDTH; s++) b = b ^ (g >> s);
        return b & MASK;
    endfunction

    function automatic int b2g(input int b);
        return (b ^ (b >> 1)) & MASK;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_step(input int r, input int c, input int v, input int g);
        int nb;
        int d;
        nb = g2b(g);
        m_step = 0;
        if (r != 0) begin
            m_state = 0; m_bin = 0; m_dir = 1; m_wraps = 0;
        end else if (c != 0) begin
            m_state = 0; m_wraps = 0;
        end else if (v != 0) begin
            if (m_state == 0) begin
                m_bin = nb; m_state = 1;
            end else if (m_state == 1) begin
                d = (nb - m_bin) & MASK;
                if (d == 0) begin
                end else if (d == 1) begin
                    if (m_bin == MASK && m_wraps < WMAX) m_wraps++;
                    m_bin = nb; m_dir = 1; m_step = 1;
                end else if (d == MASK && BIDIR != 0) begin
                    if (m_bin == 0 && m_wraps > 0) m_wraps--;
                    m_bin = nb; m_dir = 0; m_step = 1;
                end else begin
                    m_state = 2;
                end
            end
        end
    endtask

    // Drive one cycle, push the model's prediction, then pop and compare
    // against the DUT shortly after the active edge.
    task automatic drive(input int r, input int c, input int v, input int g);
        exp_t e;
        Reset = (r != 0);
        Clear = (c != 0);
        Valid = (v != 0);
        Gray  = WIDTH'(g);
        model_step(r, c, v, g);
        e.bin    = m_bin;
        e.locked = (m_state == 1) ? 1 : 0;
        e.err    = (m_state == 2) ? 1 : 0;
        e.dir    = m_dir;
        e.step   = m_step;
        e.wraps  = m_wraps;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        check("bin",    int'(Bin),    e.bin);
        check("locked", int'(Locked), e.locked);
        check("err",    int'(Err),    e.err);
        check("dir",    int'(Dir),    e.dir);
        check("step",   int'(Step),   e.step);
        check("wraps",  int'(Wraps),  e.wraps);
        if (Step) step_seen++;
    endtask

    initial begin
        int seq1 [9] = '{0, 1, 3, 2, 6, 7, 5, 4, 0};
        int pick;
        int tb;

        // Reset state
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 5);
        drive(0, 0, 0, 3);

        // Full up cycle: Bin 0..7 then 0, eight steps, one wrap
        step_seen = 0;
        foreach (seq1[i]) drive(0, 0, 1, seq1[i]);
        check("step_count", step_seen, 8);
        check("wraps_one", int'(Wraps), 1);
        check("locked_after_cycle", int'(Locked), 1);

        // Repeat same value five times: no steps
        step_seen = 0;
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 0);
        check("repeat_steps", step_seen, 0);

        // Illegal jump from Bin=1 to Gray 010 (binary 3)
        drive(1, 0, 0, 0);
        drive(0, 0, 1, 1);
        drive(0, 0, 1, 2);
        check("illegal_err", int'(Err), 1);
        check("illegal_bin_held", int'(Bin), 1);
        drive(0, 0, 1, 3);
        drive(0, 0, 1, 1);
        drive(0, 0, 0, 1);
        drive(0, 1, 0, 0);
        drive(0, 0, 1, 1);

        // Down step from Bin=2 (Gray 011) to Gray 001
        drive(0, 0, 1, 3);
        drive(0, 0, 1, 1);
`ifdef GRAY_MON_BIDIR_EN
        check("down_bin", int'(Bin), 1);
        check("down_dir", int'(Dir), 0);
`else
        check("down_bin", int'(Bin), 2);
        check("down_err", int'(Err), 1);
`endif
        drive(0, 1, 0, 0);

        // Wrap up then down across zero
        drive(0, 0, 1, 4);
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 4);
        drive(0, 0, 1, 5);
        drive(0, 1, 0, 0);

        // Saturation: five full up cycles with CNT_W=2
        drive(1, 0, 0, 0);
        drive(0, 0, 1, 0);
        for (int i = 1; i <= 40; i++) drive(0, 0, 1, b2g(i & MASK));
        check("wraps_sat", int'(Wraps), WMAX);
        drive(0, 1, 1, 1);
        check("clear_wraps", int'(Wraps), 0);
        check("clear_unlocked", int'(Locked), 0);
        drive(0, 0, 1, 1);
        check("relock", int'(Locked), 1);
        drive(0, 0, 1, 3);

        // Reset mid-sequence with Valid asserted
        drive(1, 0, 1, 2);
        check("mid_reset_bin", int'(Bin), 0);
        drive(0, 0, 1, 2);
        drive(0, 0, 1, 6);

        // Randomised mix of steps, repeats, jumps, gaps and clears
        for (int i = 0; i < 400; i++) begin
            pick = int'($urandom_range(0, 9));
            case (pick)
                0, 1, 2, 3: tb = m_bin + 1;
                4, 5:       tb = m_bin - 1;
                6:          tb = m_bin;
                default:    tb = int'($urandom_range(0, MASK));
            endcase
            drive(($urandom_range(0, 99) == 0) ? 1 : 0,
                  ($urandom_range(0, 29) == 0) ? 1 : 0,
                  ($urandom_range(0, 3) != 0) ? 1 : 0,
                  b2g(tb & MASK));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
